// File: rtl/btree_pkg.sv
// ----------------------------------------------------------------------------
// btree_pkg : shared defaults and FSM state encoding for the slot loader.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package btree_pkg;

  localparam int SLOT_COUNT_DEF = 64;
  localparam int DATA_WIDTH_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/slot_demux_loader_if.sv
// ----------------------------------------------------------------------------
// slot_demux_loader_if : load stream, random-access write and slot outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface slot_demux_loader_if
  import btree_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  localparam int IDX_W = $clog2(SLOT_COUNT);

  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_flag;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_index;
  logic                  wr_flag;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SLOT_COUNT-1:0] flags_out;
  logic [DATA_WIDTH-1:0] data_out [SLOT_COUNT];
  logic                  busy;
  logic                  done;

  modport master (
    output start, in_valid, in_flag, in_data,
    output wr_en, wr_index, wr_flag, wr_data,
    input  in_ready, flags_out, data_out, busy, done
  );

  modport slave (
    input  start, in_valid, in_flag, in_data,
    input  wr_en, wr_index, wr_flag, wr_data,
    output in_ready, flags_out, data_out, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/slot_demux_loader_decoder.sv
// ----------------------------------------------------------------------------
// slot_index_decoder : binary slot index to one-hot slot write enable.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slot_index_decoder
  import btree_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEF,
  parameter int IDX_W      = $clog2(SLOT_COUNT)
) (
  input  logic                  en,
  input  logic [IDX_W-1:0]      index,
  output logic [SLOT_COUNT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (en && (index == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/slot_demux_loader.sv
// ----------------------------------------------------------------------------
// slot_demux_loader : fills SLOT_COUNT {flag,data} slots sequentially or by
// random-access write. Option SLOT_DEMUX_CLEAR_EN clears all flags on start.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module slot_demux_loader
  import btree_pkg::*;
#(
  parameter int SLOT_COUNT = SLOT_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  slot_demux_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(SLOT_COUNT);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [SLOT_COUNT-1:0] flags_q, flags_d;
  logic [DATA_WIDTH-1:0] data_q [SLOT_COUNT];
  logic [DATA_WIDTH-1:0] data_d [SLOT_COUNT];

  logic                  load_acc;
  logic                  wr_acc;
  logic [IDX_W-1:0]      sel_index;
  logic                  sel_flag;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SLOT_COUNT-1:0] slot_we;

  // Next state / pointer. A start in IDLE wins over a same-cycle random write.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    load_acc = 1'b0;
    wr_acc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end else begin
          wr_acc = bus.wr_en;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          load_acc = 1'b1;
          ptr_d    = ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(SLOT_COUNT - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        wr_acc  = bus.wr_en;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load path and random-access path share one decoder.
  always_comb begin
    sel_index = bus.wr_index;
    sel_flag  = bus.wr_flag;
    sel_data  = bus.wr_data;
    if (load_acc) begin
      sel_index = ptr_q;
      sel_flag  = bus.in_flag;
      sel_data  = bus.in_data;
    end
  end

  slot_index_decoder #(
    .SLOT_COUNT (SLOT_COUNT),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .en     (load_acc | wr_acc),
    .index  (sel_index),
    .onehot (slot_we)
  );

  always_comb begin
    flags_d = flags_q;
    data_d  = data_q;
`ifdef SLOT_DEMUX_CLEAR_EN
    if ((state_q == ST_IDLE) && bus.start) begin
      flags_d = '0;
    end
`endif
    for (int i = 0; i < SLOT_COUNT; i++) begin
      if (slot_we[i]) begin
        flags_d[i] = sel_flag;
        data_d[i]  = sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      flags_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      flags_q <= flags_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.busy      = (state_q == ST_LOAD);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.flags_out = flags_q;
  assign bus.data_out  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_slot_demux_loader.sv
// ----------------------------------------------------------------------------
// tb_slot_demux_loader : self-checking bench for slot_demux_loader.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_slot_demux_loader;
  import btree_pkg::*;

  localparam int SC = 64;
  localparam int DW = 6;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  slot_demux_loader_if #(.SLOT_COUNT(SC), .DATA_WIDTH(DW)) bus ();

  slot_demux_loader #(.SLOT_COUNT(SC), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [SC-1:0] m_flags;
  logic [DW-1:0] m_data [SC];
  int            m_ptr;

  typedef struct {
    int          idx;
    logic        f;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int            idx;
    logic          f;
    logic [DW-1:0] d;
    logic          exp_f;
    logic [DW-1:0] exp_d;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_flags = '0;
    for (int i = 0; i < SC; i++) m_data[i] = '0;
    m_ptr = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, " flags_out"}, bus.flags_out, m_flags);
    for (int i = 0; i < SC; i++)
      check($sformatf("%s data_out[%0d]", tag, i), 64'(bus.data_out[i]), 64'(m_data[i]));
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
`ifdef SLOT_DEMUX_CLEAR_EN
    m_flags = '0;
`endif
    m_ptr = 0;
    check("busy after start", bus.busy, 1);
  endtask

  task automatic load_word(input logic f, input logic [DW-1:0] d);
    exp_t e;
    logic last;
    check("in_ready in LOAD", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_flag  = f;
    bus.in_data  = d;
    sbq.push_back('{m_ptr, f, d});
    step();
    bus.in_valid = 1'b0;
    e = sbq.pop_front();
    last = (e.idx == SC - 1);
    check($sformatf("load flag[%0d]", e.idx), bus.flags_out[e.idx], e.f);
    check($sformatf("load data[%0d]", e.idx), 64'(bus.data_out[e.idx]), 64'(e.d));
    check($sformatf("done after word %0d", e.idx), bus.done, last);
    check($sformatf("busy after word %0d", e.idx), bus.busy, !last);
    m_flags[e.idx] = e.f;
    m_data[e.idx]  = e.d;
    m_ptr = (m_ptr + 1) % SC;
  endtask

  task automatic wr_word(input int idx, input logic f, input logic [DW-1:0] d, input bit applies);
    exp_t e;
    bus.wr_en    = 1'b1;
    bus.wr_index = IW'(idx);
    bus.wr_flag  = f;
    bus.wr_data  = d;
    if (applies) sbq.push_back('{idx, f, d});
    else         sbq.push_back('{idx, m_flags[idx], m_data[idx]});
    step();
    bus.wr_en = 1'b0;
    e = sbq.pop_front();
    check($sformatf("wr flag[%0d]", e.idx), bus.flags_out[e.idx], e.f);
    check($sformatf("wr data[%0d]", e.idx), 64'(bus.data_out[e.idx]), 64'(e.d));
    m_flags[e.idx] = e.f;
    m_data[e.idx]  = e.d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc_start;
    exp_t e;

    vecs[0] = '{37, 1'b1, 6'h2A, 1'b1, 6'h2A};
    vecs[1] = '{0,  1'b1, 6'h3F, 1'b1, 6'h3F};
    vecs[2] = '{63, 1'b1, 6'h01, 1'b1, 6'h01};
    vecs[3] = '{0,  1'b0, 6'h15, 1'b0, 6'h15};
    vecs[4] = '{62, 1'b0, 6'h3C, 1'b0, 6'h3C};

    bus.start = 0; bus.in_valid = 0; bus.in_flag = 0; bus.in_data = '0;
    bus.wr_en = 0; bus.wr_index = '0; bus.wr_flag = 0; bus.wr_data = '0;
    model_reset();

    // Reset state
    #3 reset = 1'b1;
    #1;
    compare_all("reset");
    check("reset in_ready", bus.in_ready, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Random-access writes in IDLE, table-driven through the scoreboard
    for (int v = 0; v < 5; v++) begin
      bus.wr_en    = 1'b1;
      bus.wr_index = IW'(vecs[v].idx);
      bus.wr_flag  = vecs[v].f;
      bus.wr_data  = vecs[v].d;
      sbq.push_back('{vecs[v].idx, vecs[v].exp_f, vecs[v].exp_d});
      step();
      bus.wr_en = 1'b0;
      e = sbq.pop_front();
      check($sformatf("vec%0d flag", v), bus.flags_out[e.idx], e.f);
      check($sformatf("vec%0d data", v), 64'(bus.data_out[e.idx]), 64'(e.d));
      m_flags[e.idx] = e.f;
      m_data[e.idx]  = e.d;
    end
    compare_all("after vecs");

    // Full back-to-back load
    do_start();
    for (int i = 0; i < SC; i++) load_word(i[0], DW'(i));
    check("full flags", bus.flags_out, 64'hAAAA_AAAA_AAAA_AAAA);
    for (int i = 0; i < SC; i++)
      check($sformatf("full data[%0d]", i), 64'(bus.data_out[i]), 64'(i));
    step();
    check("done one cycle only", bus.done, 0);
    check("idle after done", bus.busy, 0);

    // Stall after word 10, start ignored mid-load, wr_en ignored in LOAD
    do_start();
    cyc_start = cyc;
    for (int i = 0; i <= 10; i++) begin
      if (i == 5) bus.start = 1'b1;
      load_word(!i[0], DW'(63 - i));
      bus.start = 1'b0;
    end
    for (int s = 0; s < 5; s++) begin
      if (s == 2) wr_word(3, !m_flags[3], ~m_data[3], 1'b0);
      else        step();
      check("stall busy", bus.busy, 1);
      check("stall done", bus.done, 0);
      check("stall slot11 flag", bus.flags_out[11], m_flags[11]);
      check("stall slot11 data", 64'(bus.data_out[11]), 64'(m_data[11]));
    end
    for (int i = 11; i < SC; i++) load_word(!i[0], DW'(63 - i));
    check("stall done latency", cyc - cyc_start, SC + 5);
    check("slot11 after stall", 64'(bus.data_out[11]), 64'(6'd52));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start in DONE ignored busy", bus.busy, 0);
    check("start in DONE no done", bus.done, 0);
    compare_all("after stall");

    // Flag clear option: preset every flag, then start
    for (int i = 0; i < SC; i++) wr_word(i, 1'b1, DW'(i + 3), 1'b1);
    do_start();
    compare_all("clear at start");
    for (int i = 0; i < SC; i++) load_word(i[1], DW'(i * 5));
    wr_word(9, 1'b1, 6'h11, 1'b1);
    check("wr in DONE busy", bus.busy, 0);
    compare_all("after clear load");

    // Start together with wr_en: start wins, write dropped
    bus.start    = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_index = IW'(5);
    bus.wr_flag  = !m_flags[5];
    bus.wr_data  = ~m_data[5];
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
`ifdef SLOT_DEMUX_CLEAR_EN
    m_flags = '0;
`endif
    m_ptr = 0;
    check("start+wr busy", bus.busy, 1);
    check("start+wr slot5 flag", bus.flags_out[5], m_flags[5]);
    check("start+wr slot5 data", 64'(bus.data_out[5]), 64'(m_data[5]));

    // Reset after 20 words
    for (int i = 0; i < 20; i++) load_word(1'b1, DW'(i + 40));
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("async reset");
    check("async reset busy", bus.busy, 0);
    check("async reset done", bus.done, 0);
    check("async reset in_ready", bus.in_ready, 0);
    step();
    check("reset held in_ready", bus.in_ready, 0);
    check("reset held done", bus.done, 0);
    step();
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("post reset no done", bus.done, 0);
      check("post reset idle", bus.busy, 0);
    end
    do_start();
    for (int i = 0; i < 3; i++) load_word(1'b1, DW'(i + 7));
    compare_all("fresh load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
